nalu_extract: RTL
=================

# nalu_extract

Byte-level NAL unit extractor that sits directly upstream of the bit-window RBSP buffer. It pulls raw Annex-B bytes from the bitstream source and hunts 0x000001 start codes. It latches the one-byte NAL header, strips emulation-prevention bytes (0x03 after 0x0000), and presents payload bytes one at a time on the buffer's byte-request handshake. It marks the end of each NAL unit so the slice and parameter-set parsers can resynchronise.

## Interface
Parameters: none.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  global enable; when low, no state, window or output register changes
- stream_data_in  in  8  raw Annex-B byte
- stream_valid_in  in  1  stream_data_in valid
- stream_end_in  in  1  level; source exhausted, no further bytes will arrive
- stream_rd_out  out  1  byte request to source; a byte transfers when stream_rd_out && stream_valid_in
- rd_req_by_rbsp_buffer_in  in  1  downstream byte request
- rbsp_out  out  8  payload byte (header and 0x03 bytes excluded)
- valid_data_of_nalu_out  out  1  rbsp_out holds a valid payload byte
- nal_ref_idc_out  out  2  header bits [6:5], held until the next header
- nal_unit_type_out  out  5  header bits [4:0], held until the next header
- nalu_head_valid_out  out  1  one-cycle pulse when the header is latched
- nalu_end_out  out  1  one-cycle pulse when a NAL unit's payload is complete

## Operation
- Window: 3-byte lookahead w0 (oldest), w1, w2, plus win_cnt (0..3).
- Fill: stream_rd_out = ena && !rst && (win_cnt<3 || pop). pop is the combinational "w0 leaves this cycle", decoded from registers and rd_req_by_rbsp_buffer_in.
- Zero tracking: zero_cnt counts consecutive 0x00 payload bytes, saturating at 2. It clears on a non-zero byte and on a dropped 0x03.
- Output slot is free when !valid_data_of_nalu_out, or when it is consumed this cycle (ena && valid && rd_req_by_rbsp_buffer_in).
- States:
  - SEARCH:
    - win_cnt==3 and {w0,w1,w2}==00 00 01: discard all three bytes, go to HEADER.
    - win_cnt==3 otherwise: pop w0.
    - stream_end_in with win_cnt<3: pop w0.
  - HEADER, when win_cnt>=1:
    - latch ref_idc and type from w0, pulse nalu_head_valid_out, pop w0.
    - clear zero_cnt, go to PAYLOAD.
    - forbidden_zero_bit is ignored.
  - PAYLOAD, evaluated only when the slot is free. Rules apply in priority order:
    - End pattern: (win_cnt==3 and w0==0, w1==0, w2<=1) or (stream_end_in and win_cnt==0). Pulse nalu_end_out, go to SEARCH, no pop; the start code is rescanned in SEARCH.
    - Emulation drop: zero_cnt==2 and w0==0x03 and (win_cnt==3 or stream_end_in). Pop w0 without presenting it, clear zero_cnt.
    - Emit: win_cnt==3, or stream_end_in with win_cnt>=1. Load w0 into rbsp_out, set valid, pop w0.
    - Otherwise: wait.
  - SKIP: present only with NALU_TYPE_FILTER_EN (see Configuration).
- Simultaneous pop and source transfer in one cycle: the window shifts and the new byte lands in the freed tail slot; win_cnt is unchanged.

## Timing
- Reset values:
  - state SEARCH; win_cnt 0; zero_cnt 0.
  - rbsp_out 0x00; valid_data_of_nalu_out 0.
  - nal_ref_idc_out 0; nal_unit_type_out 0.
  - nalu_head_valid_out 0; nalu_end_out 0.
  - stream_rd_out 0 while rst is high.
- rst mid-NAL: everything returns to reset values on the next edge, and any pending output byte is lost.
- Sustained throughput is 1 byte/cycle when the source is always valid and downstream always requests.
- Latency: a payload byte reaches rbsp_out at least 3 accepted bytes after it entered the window (lookahead requirement), then 1 cycle of register.
- The header pulse occurs the cycle after the header byte is in w0 and state is HEADER.
- nalu_end_out occurs only after the last payload byte has been consumed by downstream.
- rbsp_out is held stable while valid && !rd_req_by_rbsp_buffer_in.
- With ena low, pulses are not generated and stream_rd_out is 0.

## Configuration
- NALU_TYPE_FILTER_EN defined:
  - In HEADER, types other than 1, 5, 7, 8 still latch nal_ref_idc_out and nal_unit_type_out.
  - nalu_head_valid_out is not pulsed and state goes to SKIP.
  - SKIP pops bytes with no output until the PAYLOAD end pattern is seen, then goes to SEARCH with no nalu_end_out.
- Not defined: every type goes to PAYLOAD; the SKIP state is absent.

## Test plan
- Stream 00 00 00 01 67 42 00 1E 00 00 01 → one header pulse, nal_unit_type_out=7, nal_ref_idc_out=3. Payload 42,00,1E presented in order, then nalu_end_out.
- Payload 00 00 03 01 → presented bytes 00,00,01. Payload 00 00 03 03 → presented bytes 00,00,03.
- Downstream rd_req held low 5 cycles with a byte pending → rbsp_out stable, stream_rd_out low once the window is full, no byte lost.
- Trailing 00 00 00 00 01 41 → end pulse after the last real payload byte, zeros discarded, next header type 1 latched.
- rst asserted mid-payload → all outputs at reset values the next cycle, and the next start code is parsed correctly.
- With NALU_TYPE_FILTER_EN, NAL type 6 followed by type 5 → no payload or head pulse for type 6; type 5 presented normally.

Source files
------------

// File: rtl/nalu_extract.sv
// Annex-B NAL unit extractor: hunts 0x000001, latches the header byte, strips 0x03 emulation bytes.
// Optional build macro NALU_TYPE_FILTER_EN drops NAL units whose type is not 1, 5, 7 or 8.
module nalu_extract (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] stream_data_in,
  input  logic       stream_valid_in,
  input  logic       stream_end_in,
  output logic       stream_rd_out,
  input  logic       rd_req_by_rbsp_buffer_in,
  output logic [7:0] rbsp_out,
  output logic       valid_data_of_nalu_out,
  output logic [1:0] nal_ref_idc_out,
  output logic [4:0] nal_unit_type_out,
  output logic       nalu_head_valid_out,
  output logic       nalu_end_out
);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_HEADER,
`ifdef NALU_TYPE_FILTER_EN
    S_PAYLOAD,
    S_SKIP
`else
    S_PAYLOAD
`endif
  } state_t;

  function automatic logic [1:0] zc_next(input logic [1:0] zc, input logic [7:0] b);
    if (b != 8'h00) return 2'd0;
    return (zc == 2'd2) ? 2'd2 : zc + 2'd1;
  endfunction

`ifdef NALU_TYPE_FILTER_EN
  function automatic logic keep_type(input logic [4:0] t);
    return (t == 5'd1) || (t == 5'd5) || (t == 5'd7) || (t == 5'd8);
  endfunction
`endif

  state_t     state_q, state_d;
  logic [7:0] win_q [3];
  logic [7:0] win_d [3];
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] zc_q, zc_d;
  logic [7:0] rbsp_q, rbsp_d;
  logic       vld_q, vld_d;
  logic [1:0] idc_q, idc_d;
  logic [4:0] type_q, type_d;
  logic       head_q, head_d;
  logic       end_q, end_d;

  logic pop, flush, take, slot_free, start_pat, end_pat, tail_ok;

  assign slot_free = !vld_q || rd_req_by_rbsp_buffer_in;
  assign start_pat = (cnt_q == 2'd3) && (win_q[0] == 8'h00) && (win_q[1] == 8'h00) &&
                     (win_q[2] == 8'h01);
  assign end_pat   = ((cnt_q == 2'd3) && (win_q[0] == 8'h00) && (win_q[1] == 8'h00) &&
                      (win_q[2] <= 8'h01)) || (stream_end_in && (cnt_q == 2'd0));
  // w0 may leave once full lookahead exists, or once the source can supply no more
  assign tail_ok   = (cnt_q == 2'd3) || (stream_end_in && (cnt_q != 2'd0));

  assign stream_rd_out = ena && !rst && ((cnt_q != 2'd3) || pop);
  assign take          = stream_rd_out && stream_valid_in;

  always_comb begin
    state_d = state_q;
    zc_d    = zc_q;
    rbsp_d  = rbsp_q;
    vld_d   = vld_q;
    idc_d   = idc_q;
    type_d  = type_q;
    head_d  = 1'b0;
    end_d   = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    if (vld_q && rd_req_by_rbsp_buffer_in) vld_d = 1'b0;
    case (state_q)
      S_SEARCH: begin
        if (start_pat) begin
          flush   = 1'b1;
          pop     = 1'b1;
          state_d = S_HEADER;
        end else if (tail_ok) begin
          pop = 1'b1;
        end
      end
      S_HEADER: begin
        if (cnt_q != 2'd0) begin
          idc_d  = win_q[0][6:5];
          type_d = win_q[0][4:0];
          pop    = 1'b1;
          zc_d   = 2'd0;
`ifdef NALU_TYPE_FILTER_EN
          if (keep_type(win_q[0][4:0])) begin
            head_d  = 1'b1;
            state_d = S_PAYLOAD;
          end else begin
            state_d = S_SKIP;
          end
`else
          head_d  = 1'b1;
          state_d = S_PAYLOAD;
`endif
        end
      end
      S_PAYLOAD: begin
        if (slot_free) begin
          // the start code stays in the window so SEARCH rescans it
          if (end_pat) begin
            end_d   = 1'b1;
            state_d = S_SEARCH;
          end else if ((zc_q == 2'd2) && (win_q[0] == 8'h03) && tail_ok) begin
            pop  = 1'b1;
            zc_d = 2'd0;
          end else if (tail_ok) begin
            rbsp_d = win_q[0];
            vld_d  = 1'b1;
            pop    = 1'b1;
            zc_d   = zc_next(zc_q, win_q[0]);
          end
        end
      end
`ifdef NALU_TYPE_FILTER_EN
      S_SKIP: begin
        if (end_pat) state_d = S_SEARCH;
        else if (tail_ok) pop = 1'b1;
      end
`endif
      default: state_d = S_SEARCH;
    endcase
  end

  always_comb begin
    win_d = win_q;
    cnt_d = cnt_q;
    if (flush) begin
      win_d[0] = stream_data_in;
      cnt_d    = take ? 2'd1 : 2'd0;
    end else begin
      if (pop) begin
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
      end
      if (take) begin
        case (pop ? cnt_q - 2'd1 : cnt_q)
          2'd0:    win_d[0] = stream_data_in;
          2'd1:    win_d[1] = stream_data_in;
          default: win_d[2] = stream_data_in;
        endcase
      end
      cnt_d = cnt_q - {1'b0, pop} + {1'b0, take};
    end
  end

  // ena low freezes everything except the pulses, which must not stretch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SEARCH;
      cnt_q   <= 2'd0;
      zc_q    <= 2'd0;
      rbsp_q  <= 8'h00;
      vld_q   <= 1'b0;
      idc_q   <= 2'd0;
      type_q  <= 5'd0;
      head_q  <= 1'b0;
      end_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zc_q    <= zc_d;
      rbsp_q  <= rbsp_d;
      vld_q   <= vld_d;
      idc_q   <= idc_d;
      type_q  <= type_d;
      head_q  <= head_d;
      end_q   <= end_d;
    end else begin
      head_q <= 1'b0;
      end_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ena) win_q <= win_d;
  end

  assign rbsp_out               = rbsp_q;
  assign valid_data_of_nalu_out = vld_q;
  assign nal_ref_idc_out        = idc_q;
  assign nal_unit_type_out      = type_q;
  assign nalu_head_valid_out    = head_q;
  assign nalu_end_out           = end_q;

endmodule
